// File: rtl/dq_to_abc_seq.sv
// Sequential inverse Park/Clarke: rotor-frame d/q plus cos/sin to three-phase A/B/C,
// sign-magnitude fixed point, one shared multiplier and one add/sub pair sequenced by an FSM.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
// in_ready is high only in IDLE. out_valid stays high with a/b/c/sat frozen until out_ready.
module dq_to_abc_seq #(
  parameter int N     = 24,
  parameter int Q     = 12,
  parameter int K_SQ3 = 3547
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mode,
  input  logic [N-1:0] cos_q,
  input  logic [N-1:0] sin_q,
  input  logic [N-1:0] d,
  input  logic [N-1:0] q,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic [N-1:0] c,
  output logic         sat
);

  localparam int M = N - 1;

  typedef logic [N-1:0] word_t;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SUM, S_OUT} state_t;

  localparam word_t HALF = word_t'(2 ** (Q - 1));
  localparam word_t KSQ3 = word_t'(K_SQ3);

  // Result layout for the helpers below: {clamp_flag, sign, magnitude}.
  function automatic logic [N:0] sm_mul(input word_t x, input word_t y);
    logic [2*M-1:0] prod;
    logic [2*M-1:0] shifted;
    logic [M-1:0]   mag;
    logic           ovf;
    prod    = {{M{1'b0}}, x[M-1:0]} * {{M{1'b0}}, y[M-1:0]};
    shifted = prod >> Q;
    ovf     = |shifted[2*M-1:M];
    mag     = ovf ? {M{1'b1}} : shifted[M-1:0];
    return {ovf, (x[M] ^ y[M]) & (|mag), mag};
  endfunction

  function automatic logic [N:0] sm_add(input word_t x, input word_t y);
    logic [M:0]   sum;
    logic [M-1:0] mag;
    logic         sgn;
    logic         ovf;
    sum = '0;
    ovf = 1'b0;
    if (x[M] == y[M]) begin
      sum = {1'b0, x[M-1:0]} + {1'b0, y[M-1:0]};
      ovf = sum[M];
      mag = ovf ? {M{1'b1}} : sum[M-1:0];
      sgn = x[M];
    end else if (x[M-1:0] >= y[M-1:0]) begin
      mag = x[M-1:0] - y[M-1:0];
      sgn = x[M];
    end else begin
      mag = y[M-1:0] - x[M-1:0];
      sgn = y[M];
    end
    return {ovf, sgn & (|mag), mag};
  endfunction

  function automatic word_t sm_neg(input word_t x);
    return {~x[M] & (|x[M-1:0]), x[M-1:0]};
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  step_q, step_d;
  logic        mode_q, mode_d;
  word_t       cos_r_q, cos_r_d, sin_r_q, sin_r_d;
  word_t       d_r_q, d_r_d, q_r_q, q_r_d;
  word_t       p0_q, p0_d, p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  word_t       alpha_q, alpha_d, beta_q, beta_d;
  word_t       h_q, h_d, k_q, k_d;
  logic        sat_acc_q, sat_acc_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  word_t       a_q, a_d, b_q, b_d, c_q, c_d;
  logic        sat_q, sat_d;

  word_t       mul_x, mul_y, add_x, add_y, sub_x, sub_y;
  logic [N:0]  mul_r, add_r, sub_r;
  logic        ignore_mul;

  // Operand muxing for the shared arithmetic is keyed on state and step only.
  always_comb begin
    mul_x = '0;
    mul_y = '0;
    add_x = '0;
    add_y = '0;
    sub_x = '0;
    sub_y = '0;
    if (state_q == S_CALC) begin
      case (step_q)
        3'd0:    begin mul_x = cos_r_q; mul_y = d_r_q;  end
        3'd1:    begin mul_x = sin_r_q; mul_y = q_r_q;  end
        3'd2:    begin mul_x = cos_r_q; mul_y = q_r_q;  end
        3'd3:    begin mul_x = sin_r_q; mul_y = d_r_q;  end
        3'd4:    begin mul_x = alpha_q; mul_y = HALF;   end
        3'd5:    begin mul_x = beta_q;  mul_y = KSQ3;   end
        default: begin mul_x = '0;      mul_y = '0;     end
      endcase
      add_x = p2_q;
      add_y = p3_q;
      sub_x = p0_q;
      sub_y = p1_q;
    end else if (state_q == S_SUM) begin
      add_x = k_q;
      add_y = h_q;
      sub_x = k_q;
      sub_y = h_q;
    end
    mul_r = sm_mul(mul_x, mul_y);
    add_r = sm_add(add_x, add_y);
    sub_r = sm_add(sub_x, {~sub_y[M], sub_y[M-1:0]});
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    mode_d      = mode_q;
    cos_r_d     = cos_r_q;
    sin_r_d     = sin_r_q;
    d_r_d       = d_r_q;
    q_r_d       = q_r_q;
    p0_d        = p0_q;
    p1_d        = p1_q;
    p2_d        = p2_q;
    p3_d        = p3_q;
    alpha_d     = alpha_q;
    beta_d      = beta_q;
    h_d         = h_q;
    k_d         = k_q;
    sat_acc_d   = sat_acc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    sat_d       = sat_q;
    // In alpha/beta mode the h and k products are discarded, so their clamps are too.
    ignore_mul  = mode_q && (step_q >= 3'd4);

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          cos_r_d    = cos_q;
          sin_r_d    = sin_q;
          d_r_d      = d;
          q_r_d      = q;
          mode_d     = mode;
          sat_acc_d  = 1'b0;
          step_d     = 3'd0;
          in_ready_d = 1'b0;
          state_d    = S_CALC;
        end
      end
      S_CALC: begin
        sat_acc_d = sat_acc_q | (mul_r[N] & ~ignore_mul);
        case (step_q)
          3'd0: p0_d = mul_r[N-1:0];
          3'd1: p1_d = mul_r[N-1:0];
          3'd2: begin
            p2_d      = mul_r[N-1:0];
            alpha_d   = sub_r[N-1:0];
            sat_acc_d = sat_acc_q | mul_r[N] | sub_r[N];
          end
          3'd3: p3_d = mul_r[N-1:0];
          3'd4: begin
            h_d       = mul_r[N-1:0];
            beta_d    = add_r[N-1:0];
            sat_acc_d = sat_acc_q | (mul_r[N] & ~ignore_mul) | add_r[N];
          end
          3'd5: k_d = mul_r[N-1:0];
          default: ;
        endcase
        if (step_q == 3'd5) begin
          step_d  = 3'd0;
          state_d = S_SUM;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      S_SUM: begin
        a_d = alpha_q;
        if (mode_q) begin
          b_d   = beta_q;
          c_d   = '0;
          sat_d = sat_acc_q;
        end else begin
          b_d   = sub_r[N-1:0];
          c_d   = sm_neg(add_r[N-1:0]);
          sat_d = sat_acc_q | sub_r[N] | add_r[N];
        end
        out_valid_d = 1'b1;
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      step_q      <= 3'd0;
      mode_q      <= 1'b0;
      cos_r_q     <= '0;
      sin_r_q     <= '0;
      d_r_q       <= '0;
      q_r_q       <= '0;
      p0_q        <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      p3_q        <= '0;
      alpha_q     <= '0;
      beta_q      <= '0;
      h_q         <= '0;
      k_q         <= '0;
      sat_acc_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      sat_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      mode_q      <= mode_d;
      cos_r_q     <= cos_r_d;
      sin_r_q     <= sin_r_d;
      d_r_q       <= d_r_d;
      q_r_q       <= q_r_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      p3_q        <= p3_d;
      alpha_q     <= alpha_d;
      beta_q      <= beta_d;
      h_q         <= h_d;
      k_q         <= k_d;
      sat_acc_q   <= sat_acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      sat_q       <= sat_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign a         = a_q;
  assign b         = b_q;
  assign c         = c_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_dq_to_abc_seq.sv
// Bench for dq_to_abc_seq: directed vectors with hand-computed A/B/C/sat, a scoreboard
// queue filled by the driver and drained by an independent output monitor.
module tb_dq_to_abc_seq;
  localparam int N = 24;
  localparam int W = 3 * N + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         mode = 1'b0;
  logic [N-1:0] cos_q = '0;
  logic [N-1:0] sin_q = '0;
  logic [N-1:0] d = '0;
  logic [N-1:0] q = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] c;
  logic         sat;

  dq_to_abc_seq #(.N(N), .Q(12), .K_SQ3(3547)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .cos_q(cos_q), .sin_q(sin_q), .d(d), .q(q), .out_valid(out_valid),
    .out_ready(out_ready), .a(a), .b(b), .c(c), .sat(sat)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic [W-1:0] exp_q[$];
  int           lat_q[$];
  string        tag_q[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic  prev_valid = 1'b0;
  string cur_tag = "none";

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !prev_valid) begin
        if (lat_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output: out_valid rose with no sample pending");
        end else begin
          cur_tag = tag_q.pop_front();
          check_int({"latency_", cur_tag}, cyc, lat_q.pop_front());
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got %h with empty queue", {a, b, c, sat});
        end else begin
          check({"result_", cur_tag}, {a, b, c, sat}, exp_q.pop_front());
        end
      end
    end
    prev_valid <= out_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic m, input logic [N-1:0] cv, input logic [N-1:0] sv,
                      input logic [N-1:0] dv, input logic [N-1:0] qv,
                      input logic [W-1:0] exp, input string tag, input bit track);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_%s: in_ready=0 required 1", tag);
      return;
    end
    mode     = m;
    cos_q    = cv;
    sin_q    = sv;
    d        = dv;
    q        = qv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mode     = 1'($urandom);
    cos_q    = N'($urandom);
    sin_q    = N'($urandom);
    d        = N'($urandom);
    q        = N'($urandom);
    if (track) begin
      exp_q.push_back(exp);
      lat_q.push_back(cyc + 7);
      tag_q.push_back(tag);
    end
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check_int({"drain_", tag}, exp_q.size(), 0);
  endtask

  task automatic expect_idle_outputs(input string tag);
    check({tag, "_in_ready"}, W'(in_ready), W'(1));
    check({tag, "_out_valid"}, W'(out_valid), W'(0));
    check({tag, "_abc_sat"}, {a, b, c, sat}, '0);
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] exp_rot_d;

  initial begin
    exp_rot_d = {24'h001000, 24'h800800, 24'h800800, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic rotation vectors, mode 0 and mode 1.
    send(1'b0, 24'h001000, 24'h000000, 24'h001000, 24'h000000, exp_rot_d, "rot_d", 1'b1);
    send(1'b0, 24'h001000, 24'h000000, 24'h000000, 24'h001000,
         {24'h000000, 24'h000DDB, 24'h800DDB, 1'b0}, "rot_q", 1'b1);
    send(1'b1, 24'h001000, 24'h000000, 24'h000000, 24'h001000,
         {24'h000000, 24'h001000, 24'h000000, 1'b0}, "rot_q_ab", 1'b1);
    // Adder saturation on alpha, then an in-range sample must report sat=0.
    send(1'b0, 24'h001000, 24'h801000, 24'h7FF000, 24'h7FF000,
         {24'h7FFFFF, 24'hBFFFFF, 24'hBFFFFF, 1'b1}, "sat_add", 1'b1);
    send(1'b0, 24'h001000, 24'h000000, 24'h001000, 24'h000000, exp_rot_d, "after_sat", 1'b1);
    send(1'b0, 24'h001000, 24'h000000, 24'h800000, 24'h000000, '0, "neg_zero", 1'b1);
    // 60 degrees: cos=0.5, sin=0.866, d=2.0, q=-1.0.
    send(1'b0, 24'h000800, 24'h000DDB, 24'h002000, 24'h801000,
         {24'h001DDB, 24'h000224, 24'h801FFE, 1'b0}, "angle60", 1'b1);
    // Multiplier clamp in alpha/beta mode.
    send(1'b1, 24'h004000, 24'h000000, 24'h7FF000, 24'h000000,
         {24'h7FFFFF, 24'h000000, 24'h000000, 1'b1}, "sat_mul", 1'b1);
    send(1'b1, 24'h001000, 24'h000800, 24'h801000, 24'h002000,
         {24'h802000, 24'h001800, 24'h000000, 1'b0}, "neg_ab", 1'b1);
    wait_drain("directed");

    // Backpressure: hold out_ready low, pulse in_valid, outputs must stay frozen.
    out_ready = 1'b0;
    send(1'b0, 24'h001000, 24'h000000, 24'h001000, 24'h000000, exp_rot_d, "bp", 1'b1);
    begin
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", {a, b, c, sat}, exp_rot_d);
      check("bp_in_ready", W'(in_ready), W'(0));
      @(posedge clk);
      #1;
      in_valid = (i % 2 == 0);
      cos_q    = N'($urandom);
      sin_q    = N'($urandom);
      d        = N'($urandom);
      q        = N'($urandom);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_idle_in_ready", W'(in_ready), W'(1));
    check("bp_idle_out_valid", W'(out_valid), W'(0));
    repeat (12) @(posedge clk);
    #1;
    check_int("bp_no_accept", lat_q.size(), 0);

    // Reset while CALC is at step 3: the sample is dropped.
    send(1'b0, 24'h001000, 24'h000000, 24'h000000, 24'h001000, '0, "discarded", 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    expect_idle_outputs("mid_reset");
    repeat (10) @(posedge clk);
    #1;
    check("mid_reset_quiet", W'(out_valid), W'(0));
    send(1'b0, 24'h000800, 24'h000DDB, 24'h002000, 24'h801000,
         {24'h001DDB, 24'h000224, 24'h801FFE, 1'b0}, "post_reset", 1'b1);
    wait_drain("final");
    check_int("lat_q_empty", lat_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dq_to_abc_seq.md
# dq_to_abc_seq

Parametrised, sequential successor to the combinational inverse Park/Clarke stage of the vector-control path. It converts rotor-frame d/q references plus cos/sin of the rotor angle into three-phase A/B/C set-points. It uses one shared sign-magnitude fixed-point multiplier, sequenced by an FSM. It sits between the current/voltage regulators and the PWM modulator, with valid/ready handshakes on both sides, per-sample saturation reporting and an alpha/beta-only mode.

## Interface
Parameters:
- N, 24: word width, sign-magnitude (bit N-1 = sign, N-2:0 = magnitude).
- Q, 12: fractional bits.
- K_SQ3, 3547: magnitude of √3/2 in Q format, i.e. round(0.8660254·2^Q).

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- mode  in  1  0 = full dq→ABC; 1 = dq→αβ only. Sampled on accept.
- cos_q, sin_q, d, q  in  N each  sign-magnitude operands, sampled on accept.
- out_valid  out  1  A/B/C/sat hold a result.
- out_ready  in  1  downstream accepts the result.
- a, b, c  out  N each  results, sign-magnitude.
- sat  out  1  some clamp occurred while computing this sample.

## Operation
- Math:
  - α = d·cos − q·sin; β = q·cos + d·sin.
  - mode 0: A = α, B = K·β − ½α, C = −(K·β + ½α).
  - mode 1: A = α, B = β, C = +0.
- Multiply: sign = XOR of signs. Magnitude = (|x|·|y|) >> Q, truncated. If any bit above N-2 after the shift is set, the magnitude is clamped to all-ones and the sample's sat is set.
- Add/subtract: sign-magnitude. Subtraction negates the sign bit of the subtrahend. If the magnitude sum carries out of N-1 bits, clamp to all-ones and set sat. A zero magnitude always produces sign 0, so −0 is normalised to +0 on every intermediate and every output.
- FSM states and transitions:
  - IDLE: in_ready=1. on in_valid → latch operands and mode, clear sat_acc, step=0 → CALC.
  - CALC: one register write per step.
    - 0: p0 = cos·d.
    - 1: p1 = sin·q.
    - 2: p2 = cos·q; α = p0 − p1.
    - 3: p3 = sin·d.
    - 4: h = α·(2^(Q-1)); β = p2 + p3.
    - 5: k = β·K_SQ3.
    - After step 5 → SUM. In mode 1, steps 4 and 5 still run; their results are unused and their clamps are ignored.
  - SUM: register a/b/c per mode, copy sat_acc to sat, set out_valid → OUT.
  - OUT: outputs held stable. on out_ready → clear out_valid → IDLE.
- Only one multiplier instance and one adder/subtractor pair exist. Operand muxing is driven by step.

## Timing
- Reset values: in_ready=1 after reset (state IDLE); out_valid=0, a=b=c=0, sat=0, step=0, all internal registers 0.
- Latency: an accept on edge E0 makes out_valid, a, b, c and sat valid after edge E7 (7 cycles).
- Minimum initiation interval is 9 cycles: accept, 6 CALC, SUM, OUT with out_ready already high, then IDLE.
- in_ready is 0 in CALC, SUM and OUT. in_valid is ignored there, and a new sample is never accepted in the same cycle as an out_ready handshake.
- Backpressure: out_ready low holds OUT indefinitely. a, b, c and sat must not change while out_valid=1.
- Operand inputs may change freely after the accept edge. Only latched copies are used.
- rst asserted in any state: on the next edge go to IDLE, drop out_valid and zero the outputs. Any in-flight sample is discarded and never emitted. rst overrides in_valid and out_ready on the same edge.
- sat is per sample: cleared on accept, and meaningful only while out_valid=1.

## Test plan
- Rotate d only: mode 0, cos=0x001000, sin=0, d=0x001000, q=0. Expect A=0x001000, B=0x800800, C=0x800800, sat=0, out_valid exactly 7 cycles after accept.
- Rotate q only: mode 0, cos=0x001000, sin=0, d=0, q=0x001000. Expect A=0, B=0x000DDB, C=0x800DDB. With mode=1 and the same inputs, expect A=0, B=0x001000, C=0.
- Saturation: cos=0x001000, sin=0x801000, d=q=0x7FF000. Expect A=0x7FFFFF, sat=1. Send a following in-range sample and expect sat=0 for it.
- Negative zero: d=0x800000, q=0, cos=0x001000, sin=0. Expect A=B=C=0x000000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises, while pulsing in_valid with new data. Expect outputs stable, in_ready=0, and no sample accepted. Raise out_ready and expect IDLE one cycle later.
- Reset mid-operation: assert rst at CALC step 3. Expect out_valid never rising for that sample, outputs 0, and in_ready=1 on the next edge. A new sample then completes with correct values.
